dot_product_mac_hex: RTL and testbench

//   Parametrised sequential dot-product engine: holds N_PAIRS operand pairs (X[i],Y[i]), on start computes
//   sum(X[i]*Y[i]) with one multiply per clock through a 2-stage multiply/accumulate pipeline, flags overflow.

---
 rtl/dot_product_mac_hex_if.sv | 33 +++
 rtl/dot_product_mac_hex.sv | 155 +++++++++++++++
 tb/tb_dot_product_mac_hex.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/dot_product_mac_hex_if.sv
// Operand-write, control, status and display bundle for the dot-product engine.
// The bench drives the master side; the engine implements the slave side.
interface dot_product_mac_hex_if #(
   parameter int W       = 8,
   parameter int N_PAIRS = 2,
   parameter int ACC_W   = 16,
   parameter int DIGITS  = 4
);
   localparam int AW    = $clog2(2 * N_PAIRS);
   localparam int SEL_W = (N_PAIRS > 1) ? $clog2(N_PAIRS) : 1;

   logic                  wr_en;
   logic [AW-1:0]         wr_addr;
   logic [W-1:0]          wr_data;
   logic                  start;
   logic                  disp_mode;
   logic [SEL_W-1:0]      disp_sel;
   logic                  busy;
   logic                  done;
   logic [ACC_W-1:0]      result;
   logic                  ovf;
   logic [7*DIGITS-1:0]   HEX;

   modport master (
      output wr_en, wr_addr, wr_data, start, disp_mode, disp_sel,
      input  busy, done, result, ovf, HEX
   );

   modport slave (
      input  wr_en, wr_addr, wr_data, start, disp_mode, disp_sel,
      output busy, done, result, ovf, HEX
   );
endinterface

// File: rtl/dot_product_mac_hex.sv
// Sequential dot-product engine: one multiply per clock into a 2-stage MAC pipeline,
// with overflow flag and active-low 7-segment display of the result or an operand pair.
module dot_product_mac_hex #(
   parameter int W       = 8,
   parameter int N_PAIRS = 2,
   parameter int ACC_W   = 16,
   parameter int DIGITS  = 4
) (
   input  logic                   CLOCK_50,
   input  logic                   RESET_N,
   dot_product_mac_hex_if.slave   bus
);
   localparam int AW     = $clog2(2 * N_PAIRS);
   localparam int SEL_W  = (N_PAIRS > 1) ? $clog2(N_PAIRS) : 1;
   localparam int IDX_W  = (N_PAIRS > 1) ? $clog2(N_PAIRS) : 1;
   localparam int CNT_W  = $clog2(N_PAIRS + 1);
   localparam int P_W    = 2 * W;
   localparam int SUM_W  = ((ACC_W > P_W) ? ACC_W : P_W) + 1;
   localparam int DISP_W = 4 * DIGITS;

   typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

   state_t               state_q, state_d;
   logic [W-1:0]         x_reg [N_PAIRS];
   logic [W-1:0]         y_reg [N_PAIRS];
   logic [CNT_W-1:0]     idx;
   logic [P_W-1:0]       prod_q;
   logic                 prod_vld;
   logic [ACC_W-1:0]     acc;
   logic                 ovf_acc;
   logic [ACC_W-1:0]     result_q;
   logic                 ovf_q;
   logic                 busy_q;
   logic                 done_q;
   logic [SUM_W-1:0]     sum_w;
   logic                 carry;
   logic                 addr_ok;
   logic [IDX_W-1:0]     wr_pair;
   logic [DISP_W-1:0]    disp_src;
   logic                 dash;
   logic [7*DIGITS-1:0]  hex;

   function automatic logic [6:0] seg7(input logic [3:0] n);
      case (n)
         4'h0: seg7 = 7'b1000000;  4'h1: seg7 = 7'b1111001;
         4'h2: seg7 = 7'b0100100;  4'h3: seg7 = 7'b0110000;
         4'h4: seg7 = 7'b0011001;  4'h5: seg7 = 7'b0010010;
         4'h6: seg7 = 7'b0000010;  4'h7: seg7 = 7'b1111000;
         4'h8: seg7 = 7'b0000000;  4'h9: seg7 = 7'b0010000;
         4'hA: seg7 = 7'b0001000;  4'hB: seg7 = 7'b0000011;
         4'hC: seg7 = 7'b1000110;  4'hD: seg7 = 7'b0100001;
         4'hE: seg7 = 7'b0000110;  default: seg7 = 7'b0001110;
      endcase
   endfunction

   always_ff @(posedge CLOCK_50) begin
      if (!RESET_N) state_q <= IDLE;
      else          state_q <= state_d;
   end

   // The last accumulate happens on the edge where the final product is valid and idx is exhausted.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (bus.start) state_d = RUN;
         RUN:     if (prod_vld && int'(idx) == N_PAIRS) state_d = FINISH;
         FINISH:  state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   assign sum_w   = SUM_W'(acc) + SUM_W'(prod_q);
   assign carry   = |sum_w[SUM_W-1:ACC_W];
   assign addr_ok = int'(bus.wr_addr) < 2 * N_PAIRS;
   assign wr_pair = IDX_W'(bus.wr_addr >> 1);

   always_ff @(posedge CLOCK_50) begin
      if (!RESET_N) begin
         for (int i = 0; i < N_PAIRS; i++) begin
            x_reg[i] <= '0;
            y_reg[i] <= '0;
         end
         idx      <= '0;
         prod_q   <= '0;
         prod_vld <= 1'b0;
         acc      <= '0;
         ovf_acc  <= 1'b0;
         result_q <= '0;
         ovf_q    <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (bus.wr_en && addr_ok) begin
                  if (bus.wr_addr[0]) y_reg[wr_pair] <= bus.wr_data;
                  else                x_reg[wr_pair] <= bus.wr_data;
               end
               if (bus.start) begin
                  acc      <= '0;
                  idx      <= '0;
                  ovf_acc  <= 1'b0;
                  prod_vld <= 1'b0;
                  busy_q   <= 1'b1;
               end
            end
            RUN: begin
               if (int'(idx) < N_PAIRS) begin
                  prod_q   <= P_W'(x_reg[idx[IDX_W-1:0]]) * P_W'(y_reg[idx[IDX_W-1:0]]);
                  idx      <= idx + 1'b1;
                  prod_vld <= 1'b1;
               end else begin
                  prod_vld <= 1'b0;
               end
               if (prod_vld) begin
                  acc <= sum_w[ACC_W-1:0];
                  if (carry) ovf_acc <= 1'b1;
               end
            end
            FINISH: begin
               result_q <= acc;
               ovf_q    <= ovf_acc;
               done_q   <= 1'b1;
               busy_q   <= 1'b0;
            end
            default: ;
         endcase
      end
   end

   // Display source is zero-extended so unused upper digits read as 0.
   always_comb begin
      disp_src = '0;
      dash     = 1'b0;
      if (bus.disp_mode)
         disp_src = DISP_W'(result_q);
      else if (int'(bus.disp_sel) >= N_PAIRS)
         dash = 1'b1;
      else
         disp_src = DISP_W'({x_reg[bus.disp_sel], y_reg[bus.disp_sel]});
   end

   always_comb begin
      hex = '0;
      for (int i = 0; i < DIGITS; i++)
         hex[7*i +: 7] = dash ? 7'b0111111 : seg7(disp_src[4*i +: 4]);
   end

   assign bus.HEX    = hex;
   assign bus.busy   = busy_q;
   assign bus.done   = done_q;
   assign bus.result = result_q;
   assign bus.ovf    = ovf_q;
endmodule

// File: tb/tb_dot_product_mac_hex.sv
// Scoreboard bench for dot_product_mac_hex: expected sums are queued at each accepted start
// and retired against every done pulse, including its arrival cycle.
module tb_dot_product_mac_hex;
   localparam int N = 2;

   typedef struct {
      logic [15:0] res;
      logic        ovf;
      int          cyc;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   total = 0;
   int   bad = 0;
   int   cyc = 0;
   exp_t sb [$];
   logic [7:0] mx [N];
   logic [7:0] my [N];

   dot_product_mac_hex_if #(.W(8), .N_PAIRS(N), .ACC_W(16), .DIGITS(4)) bus ();
   dot_product_mac_hex_if #(.W(8), .N_PAIRS(3), .ACC_W(16), .DIGITS(4)) bus3 ();

   dot_product_mac_hex #(.W(8), .N_PAIRS(N), .ACC_W(16), .DIGITS(4)) dut (
      .CLOCK_50(clk), .RESET_N(rst_n), .bus(bus)
   );
   dot_product_mac_hex #(.W(8), .N_PAIRS(3), .ACC_W(16), .DIGITS(4)) dut3 (
      .CLOCK_50(clk), .RESET_N(rst_n), .bus(bus3)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc = cyc + 1;

   task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      total++;
      if (obs !== expv) begin
         bad++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, expv);
      end
   endtask

   // Every done pulse must match the oldest outstanding start.
   always @(negedge clk) begin
      if (bus.done) begin
         if (sb.size() == 0) begin
            check_output("unexpected_done", 32'd1, 32'd0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check_output("result", 32'(bus.result), 32'(e.res));
            check_output("ovf", 32'(bus.ovf), 32'(e.ovf));
            check_output("latency", 32'(cyc), 32'(e.cyc));
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic apply_stimulus(input logic do_wr, input logic [1:0] addr, input logic [7:0] data,
                                 input logic do_start, input logic accept);
      bus.wr_en   = do_wr;
      bus.wr_addr = addr;
      bus.wr_data = data;
      bus.start   = do_start;
      if (accept) begin
         if (do_wr) begin
            if (addr[0]) my[addr[1]] = data;
            else         mx[addr[1]] = data;
         end
         if (do_start) begin
            exp_t e;
            logic [31:0] s;
            s = 0;
            for (int i = 0; i < N; i++) s = s + 32'(mx[i]) * 32'(my[i]);
            e.res = s[15:0];
            e.ovf = s > 32'hFFFF;
            e.cyc = cyc + 1 + N + 2;
            sb.push_back(e);
         end
      end
      tick();
      bus.wr_en = 1'b0;
      bus.start = 1'b0;
   endtask

   task automatic load(input logic [7:0] x0, input logic [7:0] y0, input logic [7:0] x1, input logic [7:0] y1);
      apply_stimulus(1'b1, 2'd0, x0, 1'b0, 1'b1);
      apply_stimulus(1'b1, 2'd1, y0, 1'b0, 1'b1);
      apply_stimulus(1'b1, 2'd2, x1, 1'b0, 1'b1);
      apply_stimulus(1'b1, 2'd3, y1, 1'b0, 1'b1);
   endtask

   task automatic wait_done();
      int n;
      n = 0;
      while (sb.size() != 0 && n < 50) begin
         tick();
         n++;
      end
      if (sb.size() != 0) begin
         check_output("timeout", 32'd0, 32'd1);
         sb.delete();
      end
      repeat (3) tick();
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      sb.delete();
      for (int i = 0; i < N; i++) begin
         mx[i] = 8'h00;
         my[i] = 8'h00;
      end
   endtask

   initial begin
      bus.wr_en = 0; bus.wr_addr = 0; bus.wr_data = 0; bus.start = 0;
      bus.disp_mode = 1; bus.disp_sel = 0;
      bus3.wr_en = 0; bus3.wr_addr = 0; bus3.wr_data = 0; bus3.start = 0;
      bus3.disp_mode = 0; bus3.disp_sel = 0;
      do_reset();

      check_output("rst_result", 32'(bus.result), 32'h0);
      check_output("rst_ovf", 32'(bus.ovf), 32'h0);
      check_output("rst_busy", 32'(bus.busy), 32'h0);
      check_output("rst_done", 32'(bus.done), 32'h0);
      check_output("rst_hex", 32'(bus.HEX), 32'({4{7'b1000000}}));

      load(8'h12, 8'h34, 8'h56, 8'h78);
      apply_stimulus(1'b0, 2'd0, 8'h00, 1'b1, 1'b1);
      check_output("busy_run", 32'(bus.busy), 32'h1);
      wait_done();
      check_output("busy_after", 32'(bus.busy), 32'h0);
      check_output("hex_result", 32'(bus.HEX),
                   32'({7'b0100100, 7'b0000011, 7'b0001110, 7'b0000000}));
      bus.disp_mode = 0;
      bus.disp_sel  = 1;
      #1 check_output("hex_pair1", 32'(bus.HEX),
                      32'({7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000}));
      bus.disp_sel = 0;
      #1 check_output("hex_pair0", 32'(bus.HEX),
                      32'({7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001}));
      bus.disp_mode = 1;

      load(8'hFF, 8'hFF, 8'hFF, 8'hFF);
      apply_stimulus(1'b0, 2'd0, 8'h00, 1'b1, 1'b1);
      wait_done();
      load(8'h00, 8'h00, 8'h00, 8'h00);
      check_output("hold_result", 32'(bus.result), 32'hFC02);
      apply_stimulus(1'b0, 2'd0, 8'h00, 1'b1, 1'b1);
      wait_done();

      // Write and start on the same edge: the new X1 must be used.
      load(8'h02, 8'h03, 8'h00, 8'h05);
      apply_stimulus(1'b1, 2'd2, 8'h04, 1'b1, 1'b1);
      wait_done();

      // Start and write while busy are ignored.
      load(8'h12, 8'h34, 8'h56, 8'h78);
      apply_stimulus(1'b0, 2'd0, 8'h00, 1'b1, 1'b1);
      apply_stimulus(1'b1, 2'd0, 8'hAA, 1'b1, 1'b0);
      apply_stimulus(1'b0, 2'd0, 8'h00, 1'b1, 1'b0);
      wait_done();
      repeat (6) tick();
      bus.disp_mode = 0;
      bus.disp_sel  = 0;
      #1 check_output("x0_kept", 32'(bus.HEX[27:14]), 32'({7'b1111001, 7'b0100100}));
      bus.disp_mode = 1;

      // Reset two cycles into a run aborts it without a done pulse.
      apply_stimulus(1'b0, 2'd0, 8'h00, 1'b1, 1'b1);
      tick();
      do_reset();
      check_output("abort_result", 32'(bus.result), 32'h0);
      check_output("abort_busy", 32'(bus.busy), 32'h0);
      repeat (8) tick();
      load(8'h12, 8'h34, 8'h56, 8'h78);
      apply_stimulus(1'b0, 2'd0, 8'h00, 1'b1, 1'b1);
      wait_done();

      bus3.disp_sel = 2'd3;
      #1 check_output("dash3", 32'(bus3.HEX), 32'({4{7'b0111111}}));
      bus3.wr_en = 1; bus3.wr_addr = 3'd4; bus3.wr_data = 8'hAB;
      tick();
      bus3.wr_addr = 3'd5; bus3.wr_data = 8'hCD;
      tick();
      bus3.wr_en = 0;
      bus3.disp_sel = 2'd2;
      #1 check_output("pair2_n3", 32'(bus3.HEX),
                      32'({7'b0001000, 7'b0000011, 7'b1000110, 7'b0100001}));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
